// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, default word width and target FSM encoding.
package spi_pkg;

    localparam int unsigned SPI_DEFAULT_N = 8;

    localparam bit SPI_CPOL_LOW   = 1'b0;
    localparam bit SPI_CPOL_HIGH  = 1'b1;
    localparam bit SPI_CPHA_LEAD  = 1'b0;
    localparam bit SPI_CPHA_TRAIL = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a third flop for rise/fall detection.
module spi_sync_edge #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_port.sv
// SPI target endpoint: oversamples SCK/SSEL/MOSI in the clk domain and drives MISO,
// with the same parallel word handshake as spi_master.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int unsigned N    = SPI_DEFAULT_N,
    parameter bit          CPOL = SPI_CPOL_LOW,
    parameter bit          CPHA = SPI_CPHA_LEAD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         spi_ssel_i,
    input  logic         spi_sck_i,
    input  logic         spi_mosi_i,
    output logic         spi_miso_o,
    output logic         spi_miso_oe_o,
    output logic         di_req_o,
    input  logic [N-1:0] di_i,
    input  logic         wren_i,
    output logic         wr_ack_o,
    output logic         do_valid_o,
    output logic [N-1:0] do_o,
    output logic         underrun_o,
    output logic         busy_o
);

    localparam int unsigned CntW = $clog2(N);

    logic sck_sync_unused, sck_rise, sck_fall;
    logic ssel_sync, ssel_rise, ssel_fall;
    logic lead_ev, trail_ev, sample_ev, shift_ev;
    logic load_tx, consume;

    spi_state_e    state_q, state_d;
    logic [1:0]    mosi_q, mosi_d;
    logic [N-1:0]  hold_q, hold_d, tx_q, tx_d, rx_q, rx_d, do_q, do_d;
    logic          hold_valid_q, hold_valid_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic          do_valid_q, do_valid_d, wr_ack_q, wr_ack_d, di_req_q, di_req_d;
    logic          underrun_q, underrun_d, oe_q, oe_d;

    spi_sync_edge #(.ResetVal(CPOL)) u_sck_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (spi_sck_i),
        .sync_o  (sck_sync_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // Reset low so a select held low through reset is not mistaken for a new frame.
    spi_sync_edge #(.ResetVal(1'b0)) u_ssel_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (spi_ssel_i),
        .sync_o  (ssel_sync),
        .rise_o  (ssel_rise),
        .fall_o  (ssel_fall)
    );

    assign lead_ev   = CPOL ? sck_fall : sck_rise;
    assign trail_ev  = CPOL ? sck_rise : sck_fall;
    assign sample_ev = CPHA ? trail_ev : lead_ev;
    assign shift_ev  = CPHA ? lead_ev : trail_ev;

    always_comb begin
        state_d      = state_q;
        mosi_d       = {mosi_q[0], spi_mosi_i};
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        bit_cnt_d    = bit_cnt_q;
        do_d         = do_q;
        do_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        oe_d         = oe_q;
        wr_ack_d     = wren_i;
        load_tx      = 1'b0;
        consume      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ssel_fall) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // With CPHA=1 the first leading edge does the real load; this only drives MISO early.
                load_tx   = 1'b1;
                consume   = ~CPHA;
                bit_cnt_d = '0;
                oe_d      = 1'b1;
                state_d   = StShift;
            end
            StShift: begin
                if (ssel_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    tx_d      = '0;
                    rx_d      = '0;
                    oe_d      = 1'b0;
                end else if (sample_ev) begin
                    rx_d = {rx_q[N-2:0], mosi_q[1]};
                    if (bit_cnt_q == CntW'(N - 1)) begin
                        bit_cnt_d  = '0;
                        do_d       = rx_d;
                        do_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (shift_ev) begin
                    if (bit_cnt_q == '0) begin
                        load_tx = 1'b1;
                        consume = 1'b1;
                    end else begin
                        tx_d = {tx_q[N-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_tx) begin
            tx_d = hold_valid_q ? hold_q : '0;
            if (consume) begin
                hold_valid_d = 1'b0;
                underrun_d   = ~hold_valid_q;
            end
        end

        // A write in the same cycle as a load lands after it, so the load sees the old word.
        if (wren_i) begin
            hold_d       = di_i;
            hold_valid_d = 1'b1;
        end

        di_req_d = ~hold_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            mosi_q       <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            do_q         <= '0;
            do_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            di_req_q     <= 1'b1;
            underrun_q   <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mosi_q       <= mosi_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bit_cnt_q    <= bit_cnt_d;
            do_q         <= do_d;
            do_valid_q   <= do_valid_d;
            wr_ack_q     <= wr_ack_d;
            di_req_q     <= di_req_d;
            underrun_q   <= underrun_d;
            oe_q         <= oe_d;
        end
    end

    assign spi_miso_o    = tx_q[N-1];
    assign spi_miso_oe_o = oe_q;
    assign di_req_o      = di_req_q;
    assign wr_ack_o      = wr_ack_q;
    assign do_valid_o    = do_valid_q;
    assign do_o          = do_q;
    assign underrun_o    = underrun_q;
    assign busy_o        = (state_q != StIdle) & ~ssel_sync;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a behavioural SPI master drives mode 0 and mode 3 targets,
// expected words come from a word-level model of the holding register and frame.
module tb_spi_slave_port;

    localparam int HALF = 4;

    logic clk = 1'b0;
    logic reset, ssel, sck, mosi, wren, mode3;
    logic [7:0] di;

    logic miso0, oe0, di_req0, ack0, dv0, un0, busy0;
    logic miso3, oe3, di_req3, ack3, dv3, un3, busy3;
    logic [7:0] do0, do3;
    logic miso, oe, di_req, wr_ack, do_valid, underrun, busy;
    logic [7:0] dout;
    logic ssel0, ssel3;

    always #5 clk = ~clk;

    assign ssel0 = mode3 ? 1'b1 : ssel;
    assign ssel3 = mode3 ? ssel : 1'b1;

    spi_slave_port #(.N(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .spi_ssel_i(ssel0), .spi_sck_i(sck), .spi_mosi_i(mosi),
        .spi_miso_o(miso0), .spi_miso_oe_o(oe0), .di_req_o(di_req0), .di_i(di), .wren_i(wren),
        .wr_ack_o(ack0), .do_valid_o(dv0), .do_o(do0), .underrun_o(un0), .busy_o(busy0)
    );

    spi_slave_port #(.N(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .clk(clk), .reset(reset), .spi_ssel_i(ssel3), .spi_sck_i(sck), .spi_mosi_i(mosi),
        .spi_miso_o(miso3), .spi_miso_oe_o(oe3), .di_req_o(di_req3), .di_i(di), .wren_i(wren),
        .wr_ack_o(ack3), .do_valid_o(dv3), .do_o(do3), .underrun_o(un3), .busy_o(busy3)
    );

    assign miso     = mode3 ? miso3 : miso0;
    assign oe       = mode3 ? oe3 : oe0;
    assign di_req   = mode3 ? di_req3 : di_req0;
    assign wr_ack   = mode3 ? ack3 : ack0;
    assign do_valid = mode3 ? dv3 : dv0;
    assign dout     = mode3 ? do3 : do0;
    assign underrun = mode3 ? un3 : un0;
    assign busy     = mode3 ? busy3 : busy0;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] rx_seen[$];
    int un_cnt = 0;
    int quiet_bad = 0;
    bit quiet_en = 1'b0;

    always @(negedge clk) begin
        if (do_valid) rx_seen.push_back(dout);
        if (underrun) un_cnt++;
        if (quiet_en && ({miso, oe, di_req, wr_ack, do_valid, underrun, busy, dout} !==
                         {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})) quiet_bad++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] v);
        di = v;
        wren = 1'b1;
        tick(1);
        wren = 1'b0;
        @(negedge clk);
        check_eq("wr_ack_pulse", {31'h0, wr_ack}, 32'h1);
        check_eq("di_req_after_write", {31'h0, di_req}, 32'h0);
        @(negedge clk);
        check_eq("wr_ack_single", {31'h0, wr_ack}, 32'h0);
        tick(1);
    endtask

    task automatic spi_bit(input bit m3, input bit b, output bit mi);
        if (!m3) begin
            mosi = b;
            tick(HALF);
            mi = miso;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end else begin
            sck = 1'b0;
            mosi = b;
            tick(HALF);
            mi = miso;
            sck = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic run_frame(input bit m3, input int nwords, input logic [7:0] tx[4],
                             input int stop_bit, output logic [7:0] got[4]);
        bit mi;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;
        ssel = 1'b0;
        tick(8);
        for (int b = 0; b < nwords * 8 && b < stop_bit; b++) begin
            spi_bit(m3, tx[b/8][7 - b%8], mi);
            got[b/8] = {got[b/8][6:0], mi};
        end
        tick(4);
    endtask

    task automatic end_frame();
        ssel = 1'b1;
        tick(8);
    endtask

    // Host refill: the next queued word is written each time di_req rises.
    task automatic refill(input int cnt, input logic [7:0] vals[4]);
        logic prev;
        bit ok;
        for (int i = 1; i <= cnt; i++) begin
            ok = 1'b0;
            prev = di_req;
            for (int k = 0; k < 400 && !ok; k++) begin
                @(negedge clk);
                if (di_req && !prev) ok = 1'b1;
                prev = di_req;
            end
            check_eq("refill_di_req_rise", {31'h0, ok}, 32'h1);
            tick(1);
            host_write(vals[i]);
        end
    endtask

    task automatic frame_check(input string tag, input int nwords, input int rx_base,
                               input logic [7:0] mo[4], input logic [7:0] exp_miso[4],
                               input logic [7:0] got[4]);
        check_eq({tag, "_rx_count"}, rx_seen.size() - rx_base, nwords);
        for (int i = 0; i < nwords; i++) begin
            check_eq({tag, "_miso"}, {24'h0, got[i]}, {24'h0, exp_miso[i]});
            if (rx_base + i < rx_seen.size())
                check_eq({tag, "_rx"}, {24'h0, rx_seen[rx_base + i]}, {24'h0, mo[i]});
        end
    endtask

    task automatic random_frame(input bit m3, input string tag);
        logic [7:0] mo[4], vals[4], got[4];
        int nw, base;
        nw = $urandom_range(3, 1);
        for (int i = 0; i < 4; i++) begin
            mo[i] = 8'($urandom);
            vals[i] = 8'($urandom);
        end
        host_write(vals[0]);
        base = rx_seen.size();
        fork
            run_frame(m3, nw, mo, 99, got);
            refill(nw - 1, vals);
        join
        end_frame();
        frame_check(tag, nw, base, mo, vals, got);
    endtask

    logic [7:0] mo[4], ex[4], got[4];
    int base, un_base, lat, quiet_base;
    bit ok2;
    bit mi;

    initial begin
        reset = 1'b1; ssel = 1'b1; sck = 1'b0; mosi = 1'b0; di = 8'h00; wren = 1'b0;
        mode3 = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(2);

        @(negedge clk);
        check_eq("rst_miso", {31'h0, miso}, 32'h0);
        check_eq("rst_oe", {31'h0, oe}, 32'h0);
        check_eq("rst_di_req", {31'h0, di_req}, 32'h1);
        check_eq("rst_wr_ack", {31'h0, wr_ack}, 32'h0);
        check_eq("rst_do_valid", {31'h0, do_valid}, 32'h0);
        check_eq("rst_do", {24'h0, dout}, 32'h0);
        check_eq("rst_underrun", {31'h0, underrun}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        tick(1);

        // Single word, mode 0.
        host_write(8'hA5);
        mo[0] = 8'h3C; ex[0] = 8'hA5;
        base = rx_seen.size();
        run_frame(1'b0, 1, mo, 99, got);
        @(negedge clk);
        check_eq("t1_oe_in_frame", {31'h0, oe}, 32'h1);
        check_eq("t1_busy_in_frame", {31'h0, busy}, 32'h1);
        check_eq("t1_di_req_after_load", {31'h0, di_req}, 32'h1);
        tick(1);
        end_frame();
        frame_check("t1", 1, base, mo, ex, got);
        check_eq("t1_oe_after", {31'h0, oe}, 32'h0);

        // Three back-to-back words with host refill.
        ex[0] = 8'h11; ex[1] = 8'h22; ex[2] = 8'h33;
        for (int i = 0; i < 3; i++) mo[i] = 8'($urandom);
        host_write(ex[0]);
        base = rx_seen.size();
        fork
            run_frame(1'b0, 3, mo, 99, got);
            refill(2, ex);
        join
        end_frame();
        frame_check("t2", 3, base, mo, ex, got);

        // Empty holding register at the second word boundary.
        ex[0] = 8'($urandom); ex[1] = 8'h00; ex[2] = 8'($urandom);
        mo[0] = 8'($urandom); mo[1] = 8'($urandom);
        host_write(ex[0]);
        base = rx_seen.size();
        un_base = un_cnt;
        fork
            run_frame(1'b0, 2, mo, 99, got);
            begin
                ok2 = 1'b0;
                for (int k = 0; k < 400 && !ok2; k++) begin
                    @(negedge clk);
                    if (underrun) ok2 = 1'b1;
                end
                check_eq("t3_underrun_seen", {31'h0, ok2}, 32'h1);
                tick(20);
                host_write(ex[2]);
            end
        join
        end_frame();
        frame_check("t3", 2, base, mo, ex, got);
        check_eq("t3_underrun_count", un_cnt - un_base, 1);

        // SSEL raised after 5 bits, then a clean 0xF0 frame.
        host_write(8'($urandom));
        mo[0] = 8'($urandom);
        base = rx_seen.size();
        run_frame(1'b0, 1, mo, 5, got);
        @(negedge clk);
        check_eq("t4_oe_before_abort", {31'h0, oe}, 32'h1);
        tick(1);
        ssel = 1'b1;
        lat = 0;
        for (int k = 0; k < 10 && oe; k++) begin
            @(negedge clk);
            if (oe) lat++;
        end
        check_eq("t4_oe_drop_latency", lat, 3);
        check_eq("t4_miso_after_abort", {31'h0, miso}, 32'h0);
        tick(8);
        check_eq("t4_no_rx", rx_seen.size() - base, 0);
        ex[0] = 8'($urandom); mo[0] = 8'hF0;
        host_write(ex[0]);
        base = rx_seen.size();
        run_frame(1'b0, 1, mo, 99, got);
        end_frame();
        frame_check("t4_full", 1, base, mo, ex, got);

        for (int r = 0; r < 4; r++) random_frame(1'b0, "rand_m0");

        // Reset at bit 4, SSEL kept low: nothing may happen until SSEL toggles.
        host_write(8'($urandom));
        quiet_base = quiet_bad;
        base = rx_seen.size();
        ssel = 1'b0;
        tick(8);
        for (int b = 0; b < 4; b++) spi_bit(1'b0, 1'($urandom), mi);
        reset = 1'b1;
        tick(1);
        quiet_en = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int b = 0; b < 8; b++) spi_bit(1'b0, 1'($urandom), mi);
        tick(8);
        quiet_en = 1'b0;
        check_eq("t6_quiet_after_reset", quiet_bad - quiet_base, 0);
        check_eq("t6_no_rx", rx_seen.size() - base, 0);
        end_frame();
        ex[0] = 8'($urandom); mo[0] = 8'($urandom);
        host_write(ex[0]);
        base = rx_seen.size();
        run_frame(1'b0, 1, mo, 99, got);
        end_frame();
        frame_check("t6_after", 1, base, mo, ex, got);

        // Mode 3 (CPOL=1, CPHA=1).
        mode3 = 1'b1;
        sck = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        ex[0] = 8'h81; mo[0] = 8'h7E;
        host_write(ex[0]);
        base = rx_seen.size();
        run_frame(1'b1, 1, mo, 99, got);
        end_frame();
        frame_check("t5", 1, base, mo, ex, got);
        for (int r = 0; r < 3; r++) random_frame(1'b1, "rand_m3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2 ms, required to finish earlier");
        $fatal(1);
    end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI target (slave) endpoint: the far end of the link driven by our spi_master.
- Samples an externally supplied SCK/SSEL/MOSI in the local system clock domain and drives MISO.
- Exposes the same parallel word handshake as spi_master (di_req/di/wren/wr_ack, do_valid/do), so test rigs and loopback fabric can pair the two directly.
- Oversampled design, no SCK-clocked flops.

Parameters:
N, 8, word width in bits; MSB first on the wire.
CPOL, 0, SCK idle level.
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.

Ports:
clk  in  1  system clock; must be at least 8x SCK frequency.
reset  in  1  reset, synchronous, active-high.
spi_ssel_i  in  1  target select, active-low, asynchronous.
spi_sck_i  in  1  serial clock from master, asynchronous.
spi_mosi_i  in  1  master-out data, asynchronous.
spi_miso_o  out  1  target-out data.
spi_miso_oe_o  out  1  MISO output enable; 1 only while selected.
di_req_o  out  1  TX holding register empty (level).
di_i  in  N  TX word.
wren_i  in  1  write strobe for di_i.
wr_ack_o  out  1  one-cycle acknowledge of wren_i.
do_valid_o  out  1  one-cycle strobe: do_o holds a new RX word.
do_o  out  N  last complete RX word.
underrun_o  out  1  one-cycle pulse: word load with empty holding register.
busy_o  out  1  frame active (synchronised SSEL low).

Behaviour:
- Synchronisers: 2-FF on ssel, sck, mosi; a third sck flop feeds edge detect.
  - Internal events occur 3 clk after the pin edge.
  - Leading edge = sck transition away from CPOL; trailing edge = transition back to CPOL.
- Reset values: miso_o=0, miso_oe_o=0, di_req_o=1, wr_ack_o=0, do_valid_o=0, do_o=0, underrun_o=0, busy_o=0.
  - Shift registers, bit counter and holding-valid flag are cleared; FSM goes to IDLE.
- TX holding register:
  - wren_i=1 captures di_i and sets holding-valid.
  - wr_ack_o=1 on the next cycle.
  - di_req_o = ~holding-valid, registered.
  - A write while valid overwrites and is still acked.
  - Load and wren_i in the same cycle: the load takes the old contents; the new write is captured and valid stays 1.
- FSM states:
  - IDLE: ssel_sync high. On ssel fall → LOAD.
  - LOAD (1 cycle): tx_shift <= holding (or 0 if empty, with underrun_o pulse); holding-valid <= 0; bit_cnt <= 0; miso_oe_o <= 1. → SHIFT.
  - SHIFT: handles sample and shift events. ssel rise → IDLE.
- MISO is always tx_shift[N-1].
- Sample event: rx_shift <= {rx_shift[N-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches N: do_o <= new word, do_valid_o=1 on the following cycle, bit_cnt <= 0.
- Shift event: tx_shift <= {tx_shift[N-2:0], 0}, except at word start, where it is a load (same rules as LOAD):
  - CPHA=0: the first shift edge after the Nth sample reloads; the frame-start load comes from the LOAD state.
  - CPHA=1: the leading edge with bit_cnt==0 loads instead of shifting; the LOAD state preloads only for oe timing.
- Back-to-back words inside one frame are continuous; no gap is required from the master.
- SSEL deasserted mid-word:
  - partial RX bits discarded; no do_valid_o;
  - bit_cnt cleared;
  - unsent TX bits dropped; holding register untouched;
  - miso_oe_o=0 and miso_o=0 the cycle after ssel_sync rises.
- Sample and shift events in the same cycle cannot occur (single edge detector).
  - An SSEL rise in the same cycle as an edge takes priority: the edge is ignored.
- Reset mid-frame: immediate return to reset state. The next frame starts only after SSEL is seen high then low.

Decomposition:
- spi_pkg: CPOL/CPHA mode constants, SPI_DEFAULT_N, FSM state encoding (IDLE, LOAD, SHIFT).
- Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall detect.
  - Instantiated for sck (edges used) and for ssel (edges used).
  - mosi uses the sync output only.

Test Plan:
- N=8, mode 0, preload di_i=0xA5, master sends 0x3C with SCK=clk/8 → MISO bits 1,0,1,0,0,1,0,1; do_o=0x3C with one do_valid_o pulse; wr_ack_o one cycle after wren_i; di_req_o high again after LOAD.
- Mode 0, 3 back-to-back words in one frame; host refills on each di_req_o rise with 0x11,0x22,0x33 → MISO streams 0x11,0x22,0x33 with no gap; three do_valid_o pulses carry the master words in order.
- Empty holding at second word boundary → underrun_o pulses once; MISO second word = 0x00; RX unaffected.
- SSEL raised after 5 bits → no do_valid_o; miso_oe_o=0 the next cycle; next full frame of 0xF0 received as 0xF0 exactly.
- CPOL=1, CPHA=1, di_i=0x81, master sends 0x7E → do_o=0x7E; MISO 0x81 sampled correctly on trailing edges.
- Assert reset at bit 4 of a frame, release, keep SSEL low → no activity until SSEL toggles high then low; all outputs at reset values throughout.
